// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax sequencer: FSM state encoding,
// default vector geometry and the fp32 zero used on idle data outputs.
package softmax_pkg;

   localparam int DATA_SIZE_DEF      = 32;
   localparam int NUMBER_OF_DATA_DEF = 10;
   localparam int TIMEOUT_DEF        = 64;

   localparam logic [31:0] FP_ZERO = 32'h0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_FEED    = 3'd2,
      S_COLLECT = 3'd3,
      S_DRAIN   = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

endpackage

// File: rtl/softmax_seq_ctrl_if.sv
// Stream bundle around the softmax sequencer: upstream load, datapath feed and
// result return, downstream drain, plus status.
interface softmax_seq_ctrl_if #(
   parameter int DATA_SIZE = 32
);
   logic                 in_valid_i;
   logic [DATA_SIZE-1:0] in_data_i;
   logic                 in_ready_o;

   logic                 dp_start_o;
   logic                 dp_valid_o;
   logic [DATA_SIZE-1:0] dp_data_o;
   logic                 dp_ready_i;
   logic                 dp_result_valid_i;
   logic [DATA_SIZE-1:0] dp_result_i;

   logic                 out_valid_o;
   logic [DATA_SIZE-1:0] out_data_o;
   logic                 out_last_o;
   logic                 out_ready_i;

   logic                 busy_o;
   logic                 error_o;

   modport master (
      input  in_valid_i, in_data_i, dp_ready_i, dp_result_valid_i, dp_result_i, out_ready_i,
      output in_ready_o, dp_start_o, dp_valid_o, dp_data_o,
             out_valid_o, out_data_o, out_last_o, busy_o, error_o
   );

   modport slave (
      output in_valid_i, in_data_i, dp_ready_i, dp_result_valid_i, dp_result_i, out_ready_i,
      input  in_ready_o, dp_start_o, dp_valid_o, dp_data_o,
             out_valid_o, out_data_o, out_last_o, busy_o, error_o
   );
endinterface

// File: rtl/softmax_vec_buf.sv
// Vector buffer: one synchronous write port, one asynchronous read port.
// Contents are not reset; the controller never reads an entry before writing it.
module softmax_vec_buf
   import softmax_pkg::*;
#(
   parameter int DATA_SIZE      = DATA_SIZE_DEF,
   parameter int NUMBER_OF_DATA = NUMBER_OF_DATA_DEF,
   parameter int CNT_W          = $clog2(NUMBER_OF_DATA + 1)
) (
   input  logic                 clock_i,
   input  logic                 we,
   input  logic [CNT_W-1:0]     waddr,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic [CNT_W-1:0]     raddr,
   output logic [DATA_SIZE-1:0] rdata
);

   logic [DATA_SIZE-1:0] mem [NUMBER_OF_DATA];

   always_ff @(posedge clock_i) begin
      if (we) mem[waddr] <= wdata;
   end

   // feed_idx may sit at N after the last feed; keep the read in range
   assign rdata = (raddr < CNT_W'(NUMBER_OF_DATA)) ? mem[raddr] : DATA_SIZE'(FP_ZERO);

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencer: load one vector, replay it into the datapath, collect the
// results in place under a watchdog, then drain them downstream with a last flag.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for first word of a vector (in_ready high)
// S_LOAD    | capturing words 1..N-1 into the buffer
// S_FEED    | replaying buffer to datapath, results may already return
// S_COLLECT | all words fed, waiting for remaining results (watchdog)
// S_DRAIN   | sending results downstream, last flag on word N-1
// S_ERROR   | timeout or result overflow, held until reset
module softmax_seq_ctrl
   import softmax_pkg::*;
#(
   parameter int  DATA_SIZE      = DATA_SIZE_DEF,
   parameter int  NUMBER_OF_DATA = NUMBER_OF_DATA_DEF,
   parameter int  TIMEOUT        = TIMEOUT_DEF,
   localparam int CNT_W          = $clog2(NUMBER_OF_DATA + 1)
) (
   input  logic               clock_i,
   input  logic               reset_i,
   softmax_seq_ctrl_if.master bus
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUMBER_OF_DATA - 1);
   localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);
   localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

   state_t state, state_nxt;

   logic [CNT_W-1:0]     wr_idx, wr_idx_nxt;
   logic [CNT_W-1:0]     feed_idx, feed_idx_nxt;
   logic [CNT_W-1:0]     res_idx, res_idx_nxt;
   logic [CNT_W-1:0]     rd_idx, rd_idx_nxt;
   logic [WD_W-1:0]      wd_cnt, wd_cnt_nxt;

   logic                 buf_we;
   logic [CNT_W-1:0]     buf_waddr;
   logic [CNT_W-1:0]     buf_raddr;
   logic [DATA_SIZE-1:0] buf_wdata;
   logic [DATA_SIZE-1:0] buf_rdata;

   logic                 in_ready;
   logic                 dp_valid;
   logic                 out_valid;
   logic                 overflow;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= S_IDLE;
         wr_idx   <= '0;
         feed_idx <= '0;
         res_idx  <= '0;
         rd_idx   <= '0;
         wd_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         wr_idx   <= wr_idx_nxt;
         feed_idx <= feed_idx_nxt;
         res_idx  <= res_idx_nxt;
         rd_idx   <= rd_idx_nxt;
         wd_cnt   <= wd_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wr_idx_nxt   = wr_idx;
      feed_idx_nxt = feed_idx;
      res_idx_nxt  = res_idx;
      rd_idx_nxt   = rd_idx;
      wd_cnt_nxt   = wd_cnt;
      buf_we       = 1'b0;
      buf_waddr    = wr_idx;
      buf_wdata    = bus.in_data_i;
      in_ready     = 1'b0;
      dp_valid     = 1'b0;
      out_valid    = 1'b0;
      // a result may only land on an entry that has already been fed
      overflow     = bus.dp_result_valid_i && (res_idx == feed_idx);

      case (state)
         S_IDLE: begin
            in_ready = ~reset_i;
            if (bus.in_valid_i && in_ready) begin
               buf_we     = 1'b1;
               buf_waddr  = '0;
               wr_idx_nxt = IDX_ONE;
               state_nxt  = S_LOAD;
            end
         end

         S_LOAD: begin
            in_ready = 1'b1;
            if (bus.in_valid_i) begin
               buf_we     = 1'b1;
               wr_idx_nxt = wr_idx + IDX_ONE;
               if (wr_idx == IDX_LAST) begin
                  feed_idx_nxt = '0;
                  res_idx_nxt  = '0;
                  state_nxt    = S_FEED;
               end
            end
         end

         S_FEED: begin
            dp_valid = 1'b1;
            if (bus.dp_ready_i) feed_idx_nxt = feed_idx + IDX_ONE;
            if (overflow) begin
               state_nxt = S_ERROR;
            end else begin
               if (bus.dp_result_valid_i) begin
                  buf_we      = 1'b1;
                  buf_waddr   = res_idx;
                  buf_wdata   = bus.dp_result_i;
                  res_idx_nxt = res_idx + IDX_ONE;
                  wd_cnt_nxt  = WD_LOAD;
               end
               if (bus.dp_ready_i && (feed_idx == IDX_LAST)) begin
                  wd_cnt_nxt = WD_LOAD;
                  state_nxt  = S_COLLECT;
               end
            end
         end

         S_COLLECT: begin
            if (overflow) begin
               state_nxt = S_ERROR;
            end else if (bus.dp_result_valid_i) begin
               buf_we      = 1'b1;
               buf_waddr   = res_idx;
               buf_wdata   = bus.dp_result_i;
               res_idx_nxt = res_idx + IDX_ONE;
               wd_cnt_nxt  = WD_LOAD;
               if (res_idx == IDX_LAST) begin
                  rd_idx_nxt = '0;
                  state_nxt  = S_DRAIN;
               end
            end else if (wd_cnt == '0) begin
               state_nxt = S_ERROR;
            end else begin
               wd_cnt_nxt = wd_cnt - WD_ONE;
            end
         end

         S_DRAIN: begin
            out_valid = 1'b1;
            if (bus.out_ready_i) begin
               if (rd_idx == IDX_LAST) begin
                  wr_idx_nxt   = '0;
                  feed_idx_nxt = '0;
                  res_idx_nxt  = '0;
                  rd_idx_nxt   = '0;
                  state_nxt    = S_IDLE;
               end else begin
                  rd_idx_nxt = rd_idx + IDX_ONE;
               end
            end
         end

         S_ERROR: begin
            state_nxt = S_ERROR;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign buf_raddr = (state == S_DRAIN) ? rd_idx : feed_idx;

   softmax_vec_buf #(
      .DATA_SIZE      (DATA_SIZE),
      .NUMBER_OF_DATA (NUMBER_OF_DATA),
      .CNT_W          (CNT_W)
   ) u_vec_buf (
      .clock_i (clock_i),
      .we      (buf_we),
      .waddr   (buf_waddr),
      .wdata   (buf_wdata),
      .raddr   (buf_raddr),
      .rdata   (buf_rdata)
   );

   assign bus.in_ready_o  = in_ready;
   assign bus.dp_valid_o  = dp_valid;
   assign bus.dp_start_o  = dp_valid && (feed_idx == '0);
   assign bus.dp_data_o   = dp_valid ? buf_rdata : DATA_SIZE'(FP_ZERO);
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_valid ? buf_rdata : DATA_SIZE'(FP_ZERO);
   assign bus.out_last_o  = out_valid && (rd_idx == IDX_LAST);
   assign bus.busy_o      = (state != S_IDLE);
   assign bus.error_o     = (state == S_ERROR);

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl with a fixed-latency datapath model whose
// result for word w is w with its 16-bit halves swapped.
module tb_softmax_seq_ctrl;

   localparam int N       = 10;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   softmax_seq_ctrl_if #(.DATA_SIZE(32)) bus ();

   softmax_seq_ctrl #(
      .DATA_SIZE      (32),
      .NUMBER_OF_DATA (N),
      .TIMEOUT        (TIMEOUT)
   ) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;

   logic [31:0] vec [N] = '{32'hC05060D2, 32'h40A5D0A4, 32'hBF3A1674, 32'h401D24F6, 32'hBE3BD70A,
                            32'h3F461F7D, 32'hC0350DF4, 32'h40BEEE67, 32'hC0A6D2C4, 32'h3F9DF3B6};

   function automatic logic [31:0] f_res(input logic [31:0] w);
      return {w[15:0], w[31:16]};
   endfunction

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // datapath model state
   int          n_fed = 0;
   int          n_res = 0;
   int          res_limit = N;
   int          start_cyc = 0;
   int          last_res_cyc = 0;
   logic [31:0] start_word = 32'h0;
   logic [31:0] feed_log [N];
   logic [31:0] pend_q [$];
   int          due_q [$];

   initial begin
      bus.dp_result_valid_i = 1'b0;
      bus.dp_result_i       = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            n_fed = 0;
            n_res = 0;
            start_cyc = 0;
            pend_q.delete();
            due_q.delete();
            bus.dp_result_valid_i = 1'b0;
            bus.dp_result_i       = 32'h0;
         end else begin
            if (bus.dp_start_o) begin
               start_cyc++;
               start_word = bus.dp_data_o;
            end
            if (bus.dp_valid_o && bus.dp_ready_i) begin
               if (n_fed < N) feed_log[n_fed] = bus.dp_data_o;
               n_fed++;
               pend_q.push_back(bus.dp_data_o);
               due_q.push_back(cyc + LAT);
            end
            if (due_q.size() > 0 && due_q[0] <= cyc && n_res < res_limit) begin
               bus.dp_result_valid_i = 1'b1;
               bus.dp_result_i       = f_res(pend_q.pop_front());
               void'(due_q.pop_front());
               n_res++;
               last_res_cyc = cyc;
            end else begin
               bus.dp_result_valid_i = 1'b0;
               bus.dp_result_i       = 32'h0;
            end
         end
      end
   end

   // observations gathered by the stimulus helpers
   int          ld_accepts;
   logic        ld_ready_after;
   int          n_out;
   logic [31:0] out_log  [N];
   logic        last_log [N];
   logic        busy_after;
   logic        valid_after;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid_i  = 1'b0;
      bus.dp_ready_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_vector();
      int k = 0;
      int guard = 0;
      while (k < N && guard < 50) begin
         @(negedge clk);
         bus.in_valid_i = 1'b1;
         bus.in_data_i  = vec[k];
         #2;
         if (bus.in_ready_o) k++;
         guard++;
      end
      ld_accepts = k;
      @(negedge clk);
      bus.in_data_i = 32'hDEADBEEF;
      #2;
      ld_ready_after = bus.in_ready_o;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic collect_outputs();
      int guard = 0;
      n_out = 0;
      bus.out_ready_i = 1'b1;
      while (n_out < N && guard < 400) begin
         @(negedge clk);
         #2;
         if (bus.out_valid_o) begin
            out_log[n_out]  = bus.out_data_o;
            last_log[n_out] = bus.out_last_o;
            n_out++;
         end
         guard++;
      end
      @(negedge clk);
      #2;
      busy_after  = bus.busy_o;
      valid_after = bus.out_valid_o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = 32'h0;
      bus.dp_ready_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_mis++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready_o); end
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      n_cmp++; if (bus.error_o !== 1'b0) begin n_mis++; $display("FAIL reset_error: got %b want 0", bus.error_o); end
      n_cmp++; if ({bus.dp_valid_o, bus.dp_start_o, bus.out_valid_o, bus.out_last_o} !== 4'b0000) begin
         n_mis++; $display("FAIL reset_valids: got %b want 0000", {bus.dp_valid_o, bus.dp_start_o, bus.out_valid_o, bus.out_last_o});
      end
      @(negedge clk);
      rst = 1'b0;
      #2;
      n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_mis++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready_o); end
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_mis++; $display("FAIL release_busy: got %b want 0", bus.busy_o); end
   endtask

   task automatic test_basic();
      do_reset();
      res_limit = N;
      load_vector();
      n_cmp++; if (ld_accepts !== N) begin n_mis++; $display("FAIL basic_accepts: got %0d want %0d", ld_accepts, N); end
      n_cmp++; if (ld_ready_after !== 1'b0) begin n_mis++; $display("FAIL basic_ready_drop: got %b want 0", ld_ready_after); end
      collect_outputs();
      n_cmp++; if (n_out !== N) begin n_mis++; $display("FAIL basic_out_count: got %0d want %0d", n_out, N); end
      for (int j = 0; j < N; j++) begin
         n_cmp++; if (feed_log[j] !== vec[j]) begin n_mis++; $display("FAIL basic_feed[%0d]: got %h want %h", j, feed_log[j], vec[j]); end
         n_cmp++; if (out_log[j] !== f_res(vec[j])) begin n_mis++; $display("FAIL basic_out[%0d]: got %h want %h", j, out_log[j], f_res(vec[j])); end
         n_cmp++; if (last_log[j] !== (j == N - 1)) begin n_mis++; $display("FAIL basic_last[%0d]: got %b want %b", j, last_log[j], (j == N - 1)); end
      end
      n_cmp++; if (start_cyc !== 1) begin n_mis++; $display("FAIL basic_start_cycles: got %0d want 1", start_cyc); end
      n_cmp++; if (start_word !== vec[0]) begin n_mis++; $display("FAIL basic_start_word: got %h want %h", start_word, vec[0]); end
      n_cmp++; if (busy_after !== 1'b0) begin n_mis++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
      n_cmp++; if (valid_after !== 1'b0) begin n_mis++; $display("FAIL basic_valid_after: got %b want 0", valid_after); end
      n_cmp++; if (bus.error_o !== 1'b0) begin n_mis++; $display("FAIL basic_error: got %b want 0", bus.error_o); end
   endtask

   task automatic test_drain_stall();
      int j = 0;
      int guard = 0;
      logic stalled = 1'b0;
      logic tog = 1'b0;
      logic [31:0] held = 32'h0;
      do_reset();
      res_limit = N;
      load_vector();
      while (j < N && guard < 400) begin
         @(negedge clk);
         bus.out_ready_i = tog;
         tog = ~tog;
         #2;
         if (bus.out_valid_o) begin
            n_cmp++; if (bus.out_data_o !== f_res(vec[j])) begin n_mis++; $display("FAIL stall_out[%0d]: got %h want %h", j, bus.out_data_o, f_res(vec[j])); end
            if (stalled) begin
               n_cmp++; if (bus.out_data_o !== held) begin n_mis++; $display("FAIL stall_hold[%0d]: got %h want %h", j, bus.out_data_o, held); end
            end
            stalled = ~bus.out_ready_i;
            held    = bus.out_data_o;
            if (bus.out_ready_i) j++;
         end
         guard++;
      end
      n_cmp++; if (j !== N) begin n_mis++; $display("FAIL stall_count: got %0d want %0d", j, N); end
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      #2;
      n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_mis++; $display("FAIL stall_after: valid %b busy %b want 0 0", bus.out_valid_o, bus.busy_o);
      end
   endtask

   task automatic test_dp_stall();
      int guard = 0;
      do_reset();
      res_limit = N;
      load_vector();
      while (n_fed < 4 && guard < 50) begin
         @(negedge clk);
         #2;
         guard++;
      end
      n_cmp++; if (n_fed !== 4) begin n_mis++; $display("FAIL dpstall_reach4: got %0d want 4", n_fed); end
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         bus.dp_ready_i = 1'b0;
         #2;
         n_cmp++; if (bus.dp_valid_o !== 1'b1 || bus.dp_data_o !== vec[4]) begin
            n_mis++; $display("FAIL dpstall_hold[%0d]: valid %b data %h want 1 %h", s, bus.dp_valid_o, bus.dp_data_o, vec[4]);
         end
      end
      @(negedge clk);
      bus.dp_ready_i = 1'b1;
      collect_outputs();
      n_cmp++; if (n_out !== N) begin n_mis++; $display("FAIL dpstall_out_count: got %0d want %0d", n_out, N); end
      n_cmp++; if (n_res !== N) begin n_mis++; $display("FAIL dpstall_res_count: got %0d want %0d", n_res, N); end
      for (int j = 0; j < N; j++) begin
         n_cmp++; if (feed_log[j] !== vec[j]) begin n_mis++; $display("FAIL dpstall_feed[%0d]: got %h want %h", j, feed_log[j], vec[j]); end
         n_cmp++; if (out_log[j] !== f_res(vec[j])) begin n_mis++; $display("FAIL dpstall_out[%0d]: got %h want %h", j, out_log[j], f_res(vec[j])); end
      end
      n_cmp++; if (bus.error_o !== 1'b0) begin n_mis++; $display("FAIL dpstall_error: got %b want 0", bus.error_o); end
   endtask

   task automatic test_watchdog();
      int guard = 0;
      int err_cyc = 0;
      do_reset();
      res_limit = 6;
      load_vector();
      while (bus.error_o !== 1'b1 && guard < 300) begin
         @(negedge clk);
         #2;
         guard++;
      end
      err_cyc = cyc;
      n_cmp++; if (bus.error_o !== 1'b1) begin n_mis++; $display("FAIL wd_error_seen: got %b want 1", bus.error_o); end
      n_cmp++; if (n_res !== 6) begin n_mis++; $display("FAIL wd_res_count: got %0d want 6", n_res); end
      n_cmp++; if (err_cyc !== last_res_cyc + TIMEOUT + 1) begin
         n_mis++; $display("FAIL wd_timing: error at cycle %0d want %0d", err_cyc, last_res_cyc + TIMEOUT + 1);
      end
      bus.in_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      n_cmp++; if ({bus.dp_valid_o, bus.out_valid_o, bus.in_ready_o} !== 3'b000) begin
         n_mis++; $display("FAIL wd_valids: got %b want 000", {bus.dp_valid_o, bus.out_valid_o, bus.in_ready_o});
      end
      n_cmp++; if (bus.busy_o !== 1'b1 || bus.error_o !== 1'b1) begin
         n_mis++; $display("FAIL wd_sticky: busy %b error %b want 1 1", bus.busy_o, bus.error_o);
      end
      bus.in_valid_i = 1'b0;
      res_limit = N;
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      do_reset();
      res_limit = N;
      load_vector();
      while (n_fed < 4 && guard < 50) begin
         @(negedge clk);
         #2;
         guard++;
      end
      rst = 1'b1;
      #1;
      n_cmp++; if ({bus.dp_valid_o, bus.dp_start_o, bus.busy_o, bus.in_ready_o, bus.error_o, bus.out_valid_o} !== 6'b000000) begin
         n_mis++; $display("FAIL midrst_outputs: got %b want 000000",
                           {bus.dp_valid_o, bus.dp_start_o, bus.busy_o, bus.in_ready_o, bus.error_o, bus.out_valid_o});
      end
      n_cmp++; if (bus.dp_data_o !== 32'h0) begin n_mis++; $display("FAIL midrst_dp_data: got %h want 0", bus.dp_data_o); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      load_vector();
      n_cmp++; if (ld_accepts !== N) begin n_mis++; $display("FAIL midrst_accepts: got %0d want %0d", ld_accepts, N); end
      collect_outputs();
      n_cmp++; if (n_out !== N) begin n_mis++; $display("FAIL midrst_out_count: got %0d want %0d", n_out, N); end
      n_cmp++; if (n_fed !== N) begin n_mis++; $display("FAIL midrst_fed_count: got %0d want %0d", n_fed, N); end
      for (int j = 0; j < N; j++) begin
         n_cmp++; if (out_log[j] !== f_res(vec[j])) begin n_mis++; $display("FAIL midrst_out[%0d]: got %h want %h", j, out_log[j], f_res(vec[j])); end
      end
      n_cmp++; if (last_log[N-1] !== 1'b1) begin n_mis++; $display("FAIL midrst_last: got %b want 1", last_log[N-1]); end
      n_cmp++; if (busy_after !== 1'b0 || bus.error_o !== 1'b0) begin
         n_mis++; $display("FAIL midrst_done: busy %b error %b want 0 0", busy_after, bus.error_o);
      end
   endtask

   initial begin
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = 32'h0;
      bus.dp_ready_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      test_reset();
      test_basic();
      test_drain_stall();
      test_dp_stall();
      test_watchdog();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
      $fatal(1);
   end

endmodule

// File: doc/softmax_seq_ctrl.md
Name: softmax_seq_ctrl

Overview:
Sequencer in front of the softmax datapath (top_block). Captures one vector of NUMBER_OF_DATA IEEE-754 single-precision words from an upstream valid/ready stream into a local buffer. Replays the vector into the datapath with a start strobe, collects the same number of results with a watchdog, then drains them downstream with a last flag. Processes one vector at a time.

Parameters:
DATA_SIZE, 32, word width in bits (fp32)
NUMBER_OF_DATA, 10, words per softmax vector (N >= 2)
TIMEOUT, 64, max idle cycles between datapath results before error
CNT_W, $clog2(NUMBER_OF_DATA+1), index/counter width (derived)

Ports:
clock_i  in  1  rising-edge clock
reset_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  upstream word valid
in_data_i  in  DATA_SIZE  upstream word
in_ready_o  out  1  controller accepts word
dp_start_o  out  1  one-cycle strobe to datapath start, coincident with first fed word
dp_valid_o  out  1  word to datapath valid
dp_data_o  out  DATA_SIZE  word to datapath
dp_ready_i  in  1  datapath accepts word (tie 1 if no backpressure)
dp_result_valid_i  in  1  datapath result valid (sub_2_data_valid)
dp_result_i  in  DATA_SIZE  datapath result (sub_2_data)
out_valid_o  out  1  downstream result valid
out_data_o  out  DATA_SIZE  downstream result
out_last_o  out  1  marks Nth result
out_ready_i  in  1  downstream accepts result
busy_o  out  1  high in any state except IDLE
error_o  out  1  sticky; set on timeout or result overflow

Behaviour:
- Reset (async, any state, incl. mid-vector): state IDLE, all counters 0, all outputs 0 (in_ready_o 0 during reset; 1 the first cycle after release). Buffer contents undefined and never read before being written.
- Transfers occur only on valid&&ready at the rising edge.
- States: IDLE, LOAD, FEED, COLLECT, DRAIN, ERROR.
- IDLE: in_ready_o=1. Accepted word goes to buf[0]; wr_idx=1; go to LOAD.
- LOAD: in_ready_o=1. Accepted word goes to buf[wr_idx], wr_idx++. On the Nth accept, go to FEED next cycle; in_ready_o=0 from that cycle.
- FEED: dp_valid_o=1, dp_data_o=buf[feed_idx]. dp_start_o=1 only while feed_idx==0 and dp_valid_o is high; it holds until the first word is accepted. feed_idx++ on dp_valid_o&&dp_ready_i. After the Nth accept, go to COLLECT.
- Results: captured in FEED and COLLECT. On dp_result_valid_i, buf[res_idx] <= dp_result_i and res_idx++. A result may overwrite only an index already fed. If res_idx == feed_idx when a result arrives, that is overflow: set error_o and go to ERROR.
- A result and a feed handshake in the same cycle are both legal. The feed read is taken from the pre-write buffer value.
- Watchdog: counts cycles since the last result, or since entering COLLECT. Cleared by each result. Reaching TIMEOUT in COLLECT sets error_o and goes to ERROR.
- When res_idx reaches N, go to DRAIN with rd_idx=0.
- DRAIN: out_valid_o=1, out_data_o=buf[rd_idx], out_last_o=(rd_idx==N-1). Data is stable while out_ready_i=0. On the last handshake, go to IDLE. The next vector may be accepted the following cycle, giving one bubble.
- dp_result_valid_i outside FEED/COLLECT is ignored. No error is raised for it.
- ERROR: all valids 0, in_ready_o=0, busy_o=1. Leaves only via reset.
- Latency, no stalls: LOAD end to first dp word is 1 cycle. Last result to out_valid_o is 1 cycle.

Decomposition:
- Shared package softmax_pkg holds:
  - state enum localparams (S_IDLE..S_ERROR, 3-bit encoding)
  - DATA_SIZE and NUMBER_OF_DATA defaults
  - fp32 constant FP_ZERO=32'h0
- One sub-module, softmax_vec_buf: N x DATA_SIZE register file with 1 write port and 1 async read port. The write mux (load vs result) stays in the controller.

Test Plan:
- Load vector C05060D2, 40A5D0A4, BF3A1674, 401D24F6, BE3BD70A, 3F461F7D, C0350DF4, 40BEEE67, C0A6D2C4, 3F9DF3B6 with in_valid held -> in_ready drops after 10 accepts. dp_data replays the same 10 words in order. dp_start_o is high exactly 1 cycle, with C05060D2.
- Datapath model returns 10 results with 5-cycle latency, out_ready=1 -> 10 out handshakes in order. out_last only on the 10th. busy_o falls the cycle after. error_o stays 0.
- out_ready toggled 1/0 every cycle during DRAIN -> no word dropped or duplicated. out_data is stable while stalled.
- dp_ready_i=0 for 3 cycles mid-FEED -> dp_data_o holds. feed order is preserved. Total result count is still 10.
- Model stops after 6 results -> error_o=1 exactly TIMEOUT(64) cycles after the 6th result. All valids are 0 afterwards.
- Assert reset_i mid-FEED (after 4 words) -> outputs are 0 immediately. After release, a fresh 10-word vector completes normally.
